// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned SLICE_GATES = 9;

endpackage

// File: rtl/bit_serial_adder_nand_full_adder.sv
// One-bit full adder made of nine NANDs: two chained half-adder cells plus a carry merge.
module nand_full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic n1, n2, n3, p, n4, n5, n6;

  // First half-adder cell: p = x ^ y, n1 = ~(x & y)
  nand g1 (n1, x, y);
  nand g2 (n2, x, n1);
  nand g3 (n3, y, n1);
  nand g4 (p, n2, n3);

  // Second half-adder cell: s = p ^ cin, n4 = ~(p & cin)
  nand g5 (n4, p, cin);
  nand g6 (n5, p, n4);
  nand g7 (n6, cin, n4);
  nand g8 (s, n5, n6);

  // Carry merge: (x & y) | (p & cin)
  nand g9 (cout, n1, n4);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder/subtractor, one bit per clock through a single NAND full-adder slice.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               c;
  logic [CNT_W-1:0]   cnt;
  logic               s_bit, c_next;
  logic               accept, last;

  nand_full_adder u_slice (
    .x    (op_a[0]),
    .y    (op_b[0]),
    .cin  (c),
    .s    (s_bit),
    .cout (c_next)
  );

  assign accept = in_valid && in_ready;
  assign last   = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN:  if (cnt == LAST) state_next = DONE;
      DONE: if (out_ready) state_next = in_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Operands shift right so the slice always sees bit 0; results enter sum from the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      op_a <= a;
      op_b <= b ^ {WIDTH{sub}};
      c    <= sub;
      cnt  <= '0;
    end else if (state == RUN) begin
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
      c    <= c_next;
      sum  <= {s_bit, sum[WIDTH-1:1]};
      if (last) begin
        carry_out <= c_next;
        overflow  <= c ^ c_next;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and table-driven checks of bit_serial_adder at WIDTH=8 plus an exhaustive WIDTH=2 sweep.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready, sub;
  logic [7:0] a, b;
  logic       in_ready, out_valid, carry_out, overflow;
  logic [7:0] sum;

  logic       in_valid2, out_ready2, sub2;
  logic [1:0] a2, b2;
  logic       in_ready2, out_valid2, carry_out2, overflow2;
  logic [1:0] sum2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  bit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .carry_out(carry_out2), .overflow(overflow2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Wait for out_valid after an acceptance edge; returns cycles counted.
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vs, input logic [7:0] esum, input logic eco, input logic eov);
    int cyc;
    a = va; b = vb; sub = vs; in_valid = 1'b1; out_ready = 1'b0;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; a = 8'hxx; b = 8'hxx; sub = 1'bx;
    wait_result(cyc);
    check({name, "_latency"}, 32'(cyc), 32'd8);
    check({name, "_sum"}, 32'(sum), 32'(esum));
    check({name, "_carry"}, 32'(carry_out), 32'(eco));
    check({name, "_ovf"}, 32'(overflow), 32'(eov));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [7:0] hold_sum;
    logic       hold_co, hold_ov;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
             vecs[i].sum, vecs[i].co, vecs[i].ov);

    // Backpressure in DONE, then back-to-back consume + accept
    a = 8'h0F; b = 8'h01; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(cyc);
    check("bp_latency", 32'(cyc), 32'd8);
    hold_sum = sum; hold_co = carry_out; hold_ov = overflow;
    check("bp_sum", 32'(sum), 32'h10);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum_hold", 32'(sum), 32'(hold_sum));
      check("bp_carry_hold", 32'(carry_out), 32'(hold_co));
      check("bp_ovf_hold", 32'(overflow), 32'(hold_ov));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h02; b = 8'h03; sub = 1'b0;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b_drop", 32'(out_valid), 32'd0);
    wait_result(cyc);
    check("b2b_latency", 32'(cyc), 32'd8);
    check("b2b_sum", 32'(sum), 32'h05);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of RUN discards the operation
    a = 8'hAA; b = 8'h55; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_sum", 32'(sum), 32'd0);
    check("mrst_carry", 32'(carry_out), 32'd0);
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Exhaustive WIDTH=2 against a plain arithmetic model
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++) begin
          logic [1:0] bb, es;
          logic [2:0] full;
          logic       eov;
          int         c2;
          bb   = (s == 1) ? 2'(~y) : 2'(y);
          full = 3'(x) + 3'(bb) + 3'(s);
          es   = full[1:0];
          eov  = (x[1] == bb[1]) && (es[1] != x[1]);
          a2 = 2'(x); b2 = 2'(y); sub2 = 1'(s); in_valid2 = 1'b1;
          tick();
          in_valid2 = 1'b0;
          c2 = 0;
          while (!out_valid2 && c2 < 20) begin
            tick();
            c2++;
          end
          check($sformatf("w2_lat_%0d_%0d_%0d", x, y, s), 32'(c2), 32'd2);
          check($sformatf("w2_sum_%0d_%0d_%0d", x, y, s), 32'(sum2), 32'(es));
          check($sformatf("w2_co_%0d_%0d_%0d", x, y, s), 32'(carry_out2), 32'(full[2]));
          check($sformatf("w2_ov_%0d_%0d_%0d", x, y, s), 32'(overflow2), 32'(eov));
          out_ready2 = 1'b1;
          tick();
          out_ready2 = 1'b0;
        end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
